// File: rtl/ifu_axi_fetch_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_axi_fetch_bridge_pkg
// Purpose  : Shared types and constants for the IFU-to-AXI4-Lite fetch bridge.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_axi_fetch_bridge_pkg;

  localparam int c_def_addr_w = 32;
  localparam int c_def_data_w = 32;

  localparam logic [1:0] c_resp_okay    = 2'b00;
  // Instruction fetch, secure, unprivileged.
  localparam logic [2:0] c_arprot_instr = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Any response other than OKAY is reported to the IFU as a fetch error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != c_resp_okay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_watchdog
// Purpose  : Cycle counter that pulses o_expire once TIMEOUT_CYCLES cycles
//            have been spent with i_run high since the last clear.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_watchdog
  import ifu_axi_fetch_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int                 c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  // Expiry restarts the count so a following wait gets a full window too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_expire) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign o_expire = i_run && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ifu_axi_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ifu_axi_fetch_bridge
// Purpose  : Turns the IFU's level-held fetch request into a single
//            outstanding AXI4-Lite read and returns the word as a one-cycle
//            pulse. A flush discards whatever fetch is pending or in flight.
//            Define IFU_BRIDGE_TIMEOUT_EN to add a response watchdog that
//            answers the IFU with an error after TIMEOUT_CYCLES in R.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_axi_fetch_bridge
  import ifu_axi_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W         = c_def_addr_w,
  parameter int DATA_W         = c_def_data_w,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_ifu_araddr,
  input  logic              i_ifu_arvalid,
  output logic [DATA_W-1:0] o_ifu_rdata,
  output logic              o_ifu_rvalid,
  output logic              o_ifu_rerr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_m_araddr,
  output logic              o_m_arvalid,
  output logic [2:0]        o_m_arprot,
  input  logic              i_m_arready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  input  logic              i_m_rvalid,
  output logic              o_m_rready
);

  state_e r_state;
  logic   r_drop;     // a flush arrived while the AR was outstanding
  logic   w_expire;
  logic   w_unused;

`ifdef IFU_BRIDGE_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_run;

  assign w_wd_clear = (r_state == ST_AR);
  assign w_wd_run   = (r_state == ST_R) || (r_state == ST_DROP);

  generate
    if (1) begin : g_watchdog
      ifu_fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_run    (w_wd_run),
        .o_expire (w_expire)
      );
    end
  endgenerate
`else
  assign w_expire = 1'b0;
`endif

  // Fetches are word aligned, so the low address bits never reach the bus.
  assign w_unused = ^{i_ifu_araddr[1:0], (TIMEOUT_CYCLES > 0)};

  assign o_busy     = (r_state != ST_IDLE);
  assign o_m_arprot = c_arprot_instr;

  // Fetch sequencer: one read in flight, all IFU/AXI outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_drop       <= 1'b0;
      o_m_araddr   <= '0;
      o_m_arvalid  <= 1'b0;
      o_m_rready   <= 1'b0;
      o_ifu_rvalid <= 1'b0;
      o_ifu_rerr   <= 1'b0;
      o_ifu_rdata  <= '0;
    end else begin
      o_ifu_rvalid <= 1'b0;
      o_ifu_rerr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Flush outranks a new request; the IFU keeps it held anyway.
          if (i_ifu_arvalid && !i_flush) begin
            o_m_araddr  <= {i_ifu_araddr[ADDR_W-1:2], 2'b00};
            o_m_arvalid <= 1'b1;
            r_drop      <= 1'b0;
            r_state     <= ST_AR;
          end
        end
        ST_AR: begin
          // The AR cannot be withdrawn, so a flush only marks it for discard.
          if (i_flush) begin
            r_drop <= 1'b1;
          end
          if (i_m_arready) begin
            o_m_arvalid <= 1'b0;
            o_m_rready  <= 1'b1;
            r_state     <= (r_drop || i_flush) ? ST_DROP : ST_R;
          end
        end
        ST_R: begin
          if (i_m_rvalid) begin
            o_m_rready <= 1'b0;
            r_state    <= ST_IDLE;
            if (!i_flush) begin
              o_ifu_rvalid <= 1'b1;
              o_ifu_rdata  <= i_m_rdata;
              o_ifu_rerr   <= resp_is_err(i_m_rresp);
            end
          end else if (i_flush) begin
            r_drop  <= 1'b1;
            r_state <= ST_DROP;
          end else if (w_expire) begin
            // Answer the IFU now; the late beat is still absorbed in DROP.
            o_ifu_rvalid <= 1'b1;
            o_ifu_rerr   <= 1'b1;
            o_ifu_rdata  <= '0;
            r_drop       <= 1'b1;
            r_state      <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (i_m_rvalid || w_expire) begin
            o_m_rready <= 1'b0;
            r_drop     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_axi_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_axi_fetch_bridge
// Purpose  : Scoreboard bench for ifu_axi_fetch_bridge with an AXI4-Lite
//            slave model, directed scenarios and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_axi_fetch_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_flush = 1'b0;
  logic [AW-1:0] i_ifu_araddr = '0;
  logic          i_ifu_arvalid = 1'b0;
  logic [DW-1:0] o_ifu_rdata;
  logic          o_ifu_rvalid;
  logic          o_ifu_rerr;
  logic          o_busy;
  logic [AW-1:0] o_m_araddr;
  logic          o_m_arvalid;
  logic [2:0]    o_m_arprot;
  logic          i_m_arready = 1'b0;
  logic [DW-1:0] i_m_rdata = '0;
  logic [1:0]    i_m_rresp = '0;
  logic          i_m_rvalid = 1'b0;
  logic          o_m_rready;

  always #5 clk = ~clk;

  ifu_axi_fetch_bridge #(
    .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst (rst), .i_flush (i_flush),
    .i_ifu_araddr (i_ifu_araddr), .i_ifu_arvalid (i_ifu_arvalid),
    .o_ifu_rdata (o_ifu_rdata), .o_ifu_rvalid (o_ifu_rvalid),
    .o_ifu_rerr (o_ifu_rerr), .o_busy (o_busy),
    .o_m_araddr (o_m_araddr), .o_m_arvalid (o_m_arvalid),
    .o_m_arprot (o_m_arprot), .i_m_arready (i_m_arready),
    .i_m_rdata (i_m_rdata), .i_m_rresp (i_m_rresp),
    .i_m_rvalid (i_m_rvalid), .o_m_rready (o_m_rready)
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_pulse = 0;
  int unsigned cyc = 0;

  // Reference model: a transaction is delivered iff no flush is seen from
  // the edge after acceptance up to and including the edge of its R beat.
  bit          m_inflight = 0;
  bit          m_taint = 0;
  bit          m_ar_done = 0;
  int          m_age = 0;
  logic [AW-1:0] m_addr = '0;
  bit          ev_ar = 0;
  bit          ev_r = 0;
  bit          saw_rst = 1;

  // Slave knobs and state.
  int            k_ar_dly = 0;
  int            k_r_dly = 0;
  logic [DW-1:0] k_data = '0;
  logic [1:0]    k_resp = '0;
  bit            k_silent = 0;
  bit            sl_force = 0;
  int            sl_st = 0;
  int            sl_cnt = 0;
  bit            sl_loaded = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: observe handshakes on the clock edge and predict responses.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      saw_rst = 1; ev_ar = 0; ev_r = 0;
      m_inflight = 0; m_taint = 0; m_ar_done = 0; m_age = 0;
    end else begin
      saw_rst = 0;
      ev_ar = o_m_arvalid && i_m_arready;
      ev_r  = i_m_rvalid && o_m_rready;
      if (m_inflight) begin
        if (i_flush) m_taint = 1;
        if (m_ar_done) m_age++;
        if (ev_ar) begin m_ar_done = 1; m_age = 0; end
        if (ev_r) begin
          if (!m_taint) sb_q.push_back('{cyc, i_m_rdata, (i_m_rresp != 2'b00)});
          m_inflight = 0;
        end
`ifdef IFU_BRIDGE_TIMEOUT_EN
        else if (m_ar_done && !m_taint && m_age == TO) begin
          sb_q.push_back('{cyc, '0, 1'b1});
          m_taint = 1;
        end
`endif
      end else if (i_ifu_arvalid && !i_flush) begin
        m_inflight = 1; m_taint = 0; m_ar_done = 0; m_age = 0;
        m_addr = i_ifu_araddr & ~32'h3;
      end
    end
  end

  // AXI4-Lite slave: programmable AR/R delays, optional silence or stale beat.
  always @(negedge clk) begin
    if (saw_rst) begin
      sl_st = 0; sl_loaded = 0; i_m_arready = 0; i_m_rvalid = 0;
    end else begin
      if (sl_st == 0) begin
        i_m_rvalid = 0;
        if (ev_ar) begin
          i_m_arready = 0; sl_st = 1; sl_cnt = k_r_dly;
        end else if (o_m_arvalid) begin
          if (!sl_loaded) begin sl_cnt = k_ar_dly; sl_loaded = 1; end
          if (sl_cnt == 0) i_m_arready = 1;
          else begin i_m_arready = 0; sl_cnt--; end
        end else begin
          i_m_arready = 0;
        end
      end
      if (sl_st == 1) begin
        if (ev_r) begin
          i_m_rvalid = 0; sl_st = 0; sl_loaded = 0;
        end else if (!i_m_rvalid) begin
          if (sl_cnt > 0) sl_cnt--;
          else if (!k_silent) begin
            i_m_rvalid = 1; i_m_rdata = k_data; i_m_rresp = k_resp;
          end
        end
      end
    end
    if (sl_force) i_m_rvalid = 1;
  end

  // Monitor: pop and compare whenever a response is due or presented.
  always @(negedge clk) begin
    if (o_ifu_rvalid) n_pulse++;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      chk("ifu_rvalid", 64'(o_ifu_rvalid), 64'(1'b1));
      chk("ifu_rdata", 64'(o_ifu_rdata), 64'(mon_e.data));
      chk("ifu_rerr", 64'(o_ifu_rerr), 64'(mon_e.err));
    end else if (o_ifu_rvalid) begin
      chk("unexpected_ifu_rvalid", 64'(o_ifu_rvalid), 64'(1'b0));
    end
    if (o_m_arvalid) chk("m_araddr", 64'(o_m_araddr), 64'(m_addr));
    chk("busy", 64'(o_busy), 64'(m_inflight));
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_inflight || sb_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk({name, "_completes"}, 64'(n < 200), 64'(1'b1));
  endtask

  task automatic issue(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                       input logic [DW-1:0] data, input logic [1:0] resp);
    int n = 0;
    k_ar_dly = ar_dly; k_r_dly = r_dly; k_data = data; k_resp = resp;
    @(negedge clk);
    i_ifu_araddr = addr; i_ifu_arvalid = 1;
    while (!m_inflight && n < 50) begin @(negedge clk); n++; end
    i_ifu_arvalid = 0;
    chk("request_accepted", 64'(m_inflight), 64'(1'b1));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ifu_rvalid"}, 64'(o_ifu_rvalid), 64'(0));
    chk({name, "_ifu_rerr"},   64'(o_ifu_rerr),   64'(0));
    chk({name, "_ifu_rdata"},  64'(o_ifu_rdata),  64'(0));
    chk({name, "_m_araddr"},   64'(o_m_araddr),   64'(0));
    chk({name, "_m_arvalid"},  64'(o_m_arvalid),  64'(0));
    chk({name, "_m_rready"},   64'(o_m_rready),   64'(0));
    chk({name, "_busy"},       64'(o_busy),       64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    rst = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("m_arprot", 64'(o_m_arprot), 64'(3'b100));
    rst = 1;
    repeat (2) @(negedge clk);

    // Basic fetch with a zero-wait slave; pulse two negedges after acceptance.
    p0 = n_pulse;
    issue(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00);
    n = 0;
    while (!o_ifu_rvalid && n < 10) begin @(negedge clk); n++; end
    chk("basic_latency", 64'(n), 64'(2));
    wait_idle("basic");
    chk("basic_pulses", 64'(n_pulse - p0), 64'(1));

    // AR backpressure while the IFU address moves on.
    p0 = n_pulse;
    issue(32'h8000_0000, 4, 0, 32'h1234_5678, 2'b00);
    i_ifu_araddr = 32'h8000_0004;
    wait_idle("backpressure");
    chk("backpressure_pulses", 64'(n_pulse - p0), 64'(1));

    // Unaligned address and SLVERR.
    p0 = n_pulse;
    issue(32'h8000_0006, 0, 1, 32'hDEAD_BEEF, 2'b10);
    wait_idle("slverr");
    chk("slverr_pulses", 64'(n_pulse - p0), 64'(1));

    // Flush while AR is stalled.
    p0 = n_pulse;
    issue(32'h8000_0040, 3, 0, 32'h0000_0001, 2'b00);
    i_flush = 1;
    @(negedge clk);
    i_flush = 0;
    wait_idle("flush_ar");
    // Flush in R coincident with the R beat.
    issue(32'h8000_0080, 0, 2, 32'h0000_0002, 2'b00);
    n = 0;
    while (n < 20) begin
      @(negedge clk); #1;
      if (i_m_rvalid) break;
      n++;
    end
    i_flush = 1;
    @(negedge clk);
    i_flush = 0;
    wait_idle("flush_r");
    chk("flush_pulses", 64'(n_pulse - p0), 64'(0));
    p0 = n_pulse;
    issue(32'h8000_0100, 0, 0, 32'h0010_0093, 2'b00);
    wait_idle("after_flush");
    chk("after_flush_pulses", 64'(n_pulse - p0), 64'(1));

    // Reset while waiting in R, then a stale R beat.
    p0 = n_pulse;
    issue(32'h8000_0200, 0, 6, 32'h0000_0003, 2'b00);
    n = 0;
    while (!m_ar_done && n < 20) begin @(negedge clk); n++; end
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("reset_in_r");
    rst = 1;
    sl_force = 1;
    repeat (3) @(negedge clk);
    sl_force = 0;
    repeat (2) @(negedge clk);
    chk("stale_beat_pulses", 64'(n_pulse - p0), 64'(0));

`ifdef IFU_BRIDGE_TIMEOUT_EN
    // Silent slave: error pulse 8 cycles after entering R, late beat absorbed.
    p0 = n_pulse;
    k_silent = 1;
    issue(32'h8000_0300, 0, 0, 32'h0000_0004, 2'b00);
    n = 0;
    while (!o_ifu_rvalid && n < 40) begin @(negedge clk); n++; end
    chk("timeout_latency", 64'(n), 64'(TO + 1));
    k_silent = 0;
    wait_idle("timeout");
    chk("timeout_pulses", 64'(n_pulse - p0), 64'(1));
`endif

    // Randomized traffic with flushes, held requests and moving addresses.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!m_inflight && sb_q.size() == 0) begin
        k_ar_dly = $urandom_range(0, 4);
        k_r_dly  = $urandom_range(0, 4);
        k_data   = $urandom;
        k_resp   = 2'($urandom_range(0, 3));
      end
      i_ifu_arvalid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) i_ifu_araddr = $urandom;
      i_flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    i_ifu_arvalid = 0;
    i_flush = 0;
    wait_idle("random");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
